uart_cmd_receiver: RTL and testbench
====================================

Name: uart_cmd_receiver

Overview:
Parametrised UART receiver and command assembler for the DSP system host link. It deserialises 8N1 UART frames on uart_rx and packs CMD_BYTES consecutive bytes, least-significant byte first, into one command word. The word is presented on a valid/ready interface to the control/register block. It adds the following over the current fixed 4-byte path:
- configurable baud divisor and command length
- glitch rejection
- framing-error detection
- inter-byte timeout
- output backpressure with an overrun flag

Parameters:
CLKS_PER_BIT, 868, clk_100mhz cycles per UART bit (115200 baud at 100 MHz); legal range is 4 or more.
CMD_BYTES, 4, bytes per command; legal range is 1 to 8.
TIMEOUT_CLKS, 100000, idle clocks allowed between bytes of a partial command before it is discarded; legal range is 1 or more.

Ports:
clk_100mhz  input  1  system clock; the only clock.
reset_n  input  1  asynchronous active-low reset.
uart_rx  input  1  asynchronous serial input; idles high.
byte_valid  output  1  one-cycle pulse; a good byte was received.
byte_data  output  8  last good byte; valid while byte_valid is high.
cmd_valid  output  1  a command word is available.
cmd_data  output  8*CMD_BYTES  command word; byte 0 in [7:0].
cmd_ready  input  1  consumer accepts the word when cmd_valid and cmd_ready are both high.
frame_err  output  1  one-cycle pulse; stop bit was sampled low.
timeout_err  output  1  one-cycle pulse; a partial command was discarded.
overrun  output  1  one-cycle pulse; a completed command was dropped because the holding register was full.
byte_count  output  3  bytes of the current partial command (0 to CMD_BYTES-1).

Behaviour:
Clock and reset:
- Single clock domain.
- reset_n is asynchronous assert, synchronous deassert, supplied externally.
- On reset, all outputs are 0, the FSM goes to IDLE, and all counters and shift registers clear.
- Reset mid-frame or mid-command discards everything in progress.

Input synchroniser:
- uart_rx passes through 2 flops, reset value 1; rxs is the synchronised signal.
- All FSM decisions use rxs; input latency is 2 cycles.

FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: when rxs=0, go to START and load the bit counter with CLKS_PER_BIT/2-1.
- START: at counter 0, check rxs.
  - rxs=0: go to DATA with counter CLKS_PER_BIT-1 and bit index 0.
  - rxs=1: treat as a glitch, return to IDLE, no outputs.
- DATA: at each counter 0, shift rxs in LSB-first and reload the counter. After bit 7, go to STOP.
- STOP: at counter 0, sample rxs.
  - rxs=1: on the next cycle byte_valid=1, byte_data=the byte; go to IDLE.
  - rxs=0: frame_err pulses; the byte and any partial command are discarded and byte_count becomes 0; go to BREAK.
- BREAK: stay until rxs=1, then go to IDLE.

Command assembly:
- Each good byte is written to slot byte_count of the assembly register, then byte_count increments.
- When slot CMD_BYTES-1 is written, byte_count becomes 0 and the word is transferred to the holding register on the same cycle as byte_valid.
  - Holding register empty, or emptying this cycle through a handshake: cmd_valid=1 on the following cycle.
  - Holding register full and not handshaking: overrun pulses, the new word is dropped, the held word is unchanged.
- cmd_data is stable while cmd_valid=1 and cmd_ready=0.
- cmd_valid falls the cycle after the handshake.

Timeout:
- The timeout counter runs only when byte_count is not 0 and the FSM is in IDLE.
- It resets on every start-bit detection.
- When it reaches TIMEOUT_CLKS: timeout_err pulses and byte_count becomes 0.
- A start bit detected on the same cycle takes priority; no timeout fires.

Simultaneous events:
- A handshake and a new completed word in the same cycle load the new word; cmd_valid stays 1 and there is no overrun.
- Only one error pulse can occur per cycle, because the error sources are mutually exclusive by FSM state.

Arithmetic:
- Counter widths are $clog2(CLKS_PER_BIT) and $clog2(TIMEOUT_CLKS+1).
- Counters never wrap; they reload explicitly.

Test Plan:
All scenarios use CLKS_PER_BIT=16, CMD_BYTES=4, TIMEOUT_CLKS=2000, cmd_ready=1 unless stated.
1. Send bytes 01 00 00 00 -> four byte_valid pulses with the matching data, then cmd_valid for 1 cycle with cmd_data=0x00000001; byte_count ends at 0.
2. Drive uart_rx low for 5 clocks, then high -> no byte_valid, no errors; a following byte A5 is received as A5.
3. Send EF, then a frame of BE with stop bit 0 -> frame_err pulses once and byte_count=0. Then send EF BE AD DE -> cmd_data=0xDEADBEEF.
4. Send 2 bytes, then idle 2500 clocks -> timeout_err pulses once after 2000 idle clocks and byte_count goes 2 to 0; the next 4-byte command is correct.
5. Hold cmd_ready=0 and send commands 0x11111111 then 0x22222222 -> cmd_data stays 0x11111111 and overrun pulses once. Then raise cmd_ready -> a single handshake of 0x11111111, then cmd_valid=0.
6. Assert reset_n=0 during data bit 3 of byte 2 -> all outputs are 0 immediately; after release, a full command 0xCAFEF00D is received correctly.

Source files
------------

// File: rtl/uart_cmd_receiver.sv
// 8N1 UART receiver that packs CMD_BYTES bytes, LSB first, into a command word
// with valid/ready output, glitch rejection, framing/timeout errors and overrun.
module uart_cmd_receiver #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CMD_BYTES    = 4,
  parameter int TIMEOUT_CLKS = 100000
) (
  input  logic                   clk_100mhz,
  input  logic                   reset_n,
  input  logic                   uart_rx,
  output logic                   byte_valid,
  output logic [7:0]             byte_data,
  output logic                   cmd_valid,
  output logic [8*CMD_BYTES-1:0] cmd_data,
  input  logic                   cmd_ready,
  output logic                   frame_err,
  output logic                   timeout_err,
  output logic                   overrun,
  output logic [2:0]             byte_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam int WW = 8 * CMD_BYTES;
  localparam logic [CW-1:0] HALF_BIT  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
  localparam logic [2:0]    LAST_SLOT = 3'(CMD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rxs_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic [7:0]      byte_data_q, byte_data_d;
  logic            frame_err_q, frame_err_d;
  logic            timeout_err_q, timeout_err_d;
  logic            overrun_q, overrun_d;
  logic [2:0]      byte_count_q, byte_count_d;
  logic [WW-1:0]   asm_q, asm_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [WW-1:0]   cmd_data_q, cmd_data_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            handshake_s;
  logic            start_det_s;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    byte_valid_d  = 1'b0;
    byte_data_d   = byte_data_q;
    frame_err_d   = 1'b0;
    timeout_err_d = 1'b0;
    overrun_d     = 1'b0;
    byte_count_d  = byte_count_q;
    asm_d         = asm_q;
    cmd_data_d    = cmd_data_q;
    tmo_d         = tmo_q;
    handshake_s   = cmd_valid_q & cmd_ready;
    start_det_s   = (state_q == S_IDLE) && !rxs_q;
    cmd_valid_d   = cmd_valid_q & ~handshake_s;

    // Command assembly and inter-byte timeout; the timeout counter only advances
    // while idling inside a partial command and restarts at each start bit.
    if (byte_valid_q) begin
      asm_d[{byte_count_q, 3'b000} +: 8] = byte_data_q;
      if (byte_count_q == LAST_SLOT) begin
        byte_count_d = 3'd0;
        if (!cmd_valid_q || handshake_s) begin
          cmd_data_d  = asm_d;
          cmd_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        byte_count_d = byte_count_q + 3'd1;
      end
    end else if (start_det_s) begin
      tmo_d = '0;
    end else if ((state_q == S_IDLE) && (byte_count_q != 3'd0)) begin
      if (tmo_q == TMO_LAST) begin
        timeout_err_d = 1'b1;
        byte_count_d  = 3'd0;
        tmo_d         = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = HALF_BIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rxs_q) begin
          state_d   = S_DATA;
          cnt_d     = FULL_BIT;
          bit_idx_d = 3'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d = {rxs_q, shift_q[7:1]};
          cnt_d   = FULL_BIT;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rxs_q) begin
          byte_valid_d = 1'b1;
          byte_data_d  = shift_q;
          state_d      = S_IDLE;
        end else begin
          // A low stop bit also throws away the partial command.
          frame_err_d  = 1'b1;
          byte_count_d = 3'd0;
          state_d      = S_BREAK;
        end
      end
      S_BREAK: begin
        if (rxs_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BREAK;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q     <= 1'b1;
      rxs_q         <= 1'b1;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'd0;
      byte_valid_q  <= 1'b0;
      byte_data_q   <= 8'd0;
      frame_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
      byte_count_q  <= 3'd0;
      asm_q         <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_data_q    <= '0;
      tmo_q         <= '0;
    end else begin
      rx_meta_q     <= uart_rx;
      rxs_q         <= rx_meta_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      byte_valid_q  <= byte_valid_d;
      byte_data_q   <= byte_data_d;
      frame_err_q   <= frame_err_d;
      timeout_err_q <= timeout_err_d;
      overrun_q     <= overrun_d;
      byte_count_q  <= byte_count_d;
      asm_q         <= asm_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_data_q    <= cmd_data_d;
      tmo_q         <= tmo_d;
    end
  end

  assign byte_valid  = byte_valid_q;
  assign byte_data   = byte_data_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_data    = cmd_data_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_err_q;
  assign overrun     = overrun_q;
  assign byte_count  = byte_count_q;

endmodule

// File: tb/tb_uart_cmd_receiver.sv
// Directed bench for uart_cmd_receiver: bytes are driven as 8N1 frames and a
// negedge monitor logs byte pulses, error pulses and command handshakes.
module tb_uart_cmd_receiver;

  localparam int CPB = 16;

  logic        clk_100mhz = 1'b0;
  logic        reset_n    = 1'b0;
  logic        uart_rx    = 1'b1;
  logic        cmd_ready  = 1'b1;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        frame_err;
  logic        timeout_err;
  logic        overrun;
  logic [2:0]  byte_count;

  uart_cmd_receiver #(
    .CLKS_PER_BIT(CPB),
    .CMD_BYTES(4),
    .TIMEOUT_CLKS(2000)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .reset_n    (reset_n),
    .uart_rx    (uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .frame_err  (frame_err),
    .timeout_err(timeout_err),
    .overrun    (overrun),
    .byte_count (byte_count)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int checks   = 0;
  int failures = 0;
  logic [7:0]  byte_log[$];
  logic [31:0] cmd_log[$];
  int n_ferr = 0;
  int n_tmo  = 0;
  int n_ovr  = 0;
  int n_cv   = 0;

  always @(negedge clk_100mhz) begin
    if (byte_valid) byte_log.push_back(byte_data);
    if (frame_err) n_ferr++;
    if (timeout_err) n_tmo++;
    if (overrun) n_ovr++;
    if (cmd_valid) n_cv++;
    if (cmd_valid && cmd_ready) cmd_log.push_back(cmd_data);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_100mhz);
      #2;
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    uart_rx = v;
    tick(n);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    drive_bit(stop, CPB);
    drive_bit(1'b1, 4);
  endtask

  task automatic send_cmd(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    uart_rx = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(3);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb, nc, ef, et, eo, ecv;
    logic [7:0] exp_b[4];

    // Reset state
    reset_n = 1'b0;
    tick(2);
    #1;
    check_eq("rst_byte_valid", {63'd0, byte_valid}, 64'd0);
    check_eq("rst_cmd_valid", {63'd0, cmd_valid}, 64'd0);
    check_eq("rst_cmd_data", {32'd0, cmd_data}, 64'd0);
    check_eq("rst_byte_count", {61'd0, byte_count}, 64'd0);
    reset_n = 1'b1;
    tick(3);

    // 1: basic command 0x00000001
    nb = byte_log.size(); nc = cmd_log.size(); ecv = n_cv;
    send_cmd(32'h0000_0001);
    tick(20);
    exp_b[0] = 8'h01; exp_b[1] = 8'h00; exp_b[2] = 8'h00; exp_b[3] = 8'h00;
    check_eq("t1_nbytes", 64'(byte_log.size() - nb), 64'd4);
    for (int i = 0; i < 4; i++) check_eq("t1_byte", {56'd0, byte_log[nb + i]}, {56'd0, exp_b[i]});
    check_eq("t1_ncmd", 64'(cmd_log.size() - nc), 64'd1);
    check_eq("t1_cmd", {32'd0, cmd_log[nc]}, 64'h0000_0001);
    check_eq("t1_cv_cycles", 64'(n_cv - ecv), 64'd1);
    check_eq("t1_byte_count", {61'd0, byte_count}, 64'd0);

    // 2: start-bit glitch rejected, then A5 received
    do_reset();
    nb = byte_log.size(); ef = n_ferr; et = n_tmo;
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 40);
    check_eq("t2_glitch_nbytes", 64'(byte_log.size() - nb), 64'd0);
    check_eq("t2_glitch_ferr", 64'(n_ferr - ef), 64'd0);
    check_eq("t2_glitch_tmo", 64'(n_tmo - et), 64'd0);
    send_byte(8'hA5, 1'b1);
    tick(5);
    check_eq("t2_nbytes", 64'(byte_log.size() - nb), 64'd1);
    check_eq("t2_byte", {56'd0, byte_log[nb]}, 64'hA5);
    check_eq("t2_byte_count", {61'd0, byte_count}, 64'd1);

    // 3: framing error discards partial command
    do_reset();
    nb = byte_log.size(); nc = cmd_log.size(); ef = n_ferr;
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b0);
    tick(10);
    check_eq("t3_ferr", 64'(n_ferr - ef), 64'd1);
    check_eq("t3_byte_count", {61'd0, byte_count}, 64'd0);
    check_eq("t3_nbytes", 64'(byte_log.size() - nb), 64'd1);
    send_cmd(32'hDEAD_BEEF);
    tick(20);
    check_eq("t3_ncmd", 64'(cmd_log.size() - nc), 64'd1);
    check_eq("t3_cmd", {32'd0, cmd_log[nc]}, 64'hDEAD_BEEF);

    // 4: inter-byte timeout
    do_reset();
    nc = cmd_log.size(); et = n_tmo;
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    check_eq("t4_count_before", {61'd0, byte_count}, 64'd2);
    tick(1890);
    check_eq("t4_no_early_tmo", 64'(n_tmo - et), 64'd0);
    check_eq("t4_count_held", {61'd0, byte_count}, 64'd2);
    tick(606);
    check_eq("t4_tmo", 64'(n_tmo - et), 64'd1);
    check_eq("t4_count_after", {61'd0, byte_count}, 64'd0);
    send_cmd(32'h8765_4321);
    tick(20);
    check_eq("t4_ncmd", 64'(cmd_log.size() - nc), 64'd1);
    check_eq("t4_cmd", {32'd0, cmd_log[nc]}, 64'h8765_4321);

    // 5: backpressure and overrun
    do_reset();
    nc = cmd_log.size(); eo = n_ovr;
    cmd_ready = 1'b0;
    send_cmd(32'h1111_1111);
    send_cmd(32'h2222_2222);
    tick(5);
    check_eq("t5_cmd_valid", {63'd0, cmd_valid}, 64'd1);
    check_eq("t5_cmd_held", {32'd0, cmd_data}, 64'h1111_1111);
    check_eq("t5_overrun", 64'(n_ovr - eo), 64'd1);
    check_eq("t5_no_hs", 64'(cmd_log.size() - nc), 64'd0);
    cmd_ready = 1'b1;
    tick(6);
    check_eq("t5_nhs", 64'(cmd_log.size() - nc), 64'd1);
    check_eq("t5_hs_data", {32'd0, cmd_log[nc]}, 64'h1111_1111);
    check_eq("t5_cv_low", {63'd0, cmd_valid}, 64'd0);

    // 6: reset in data bit 3 of byte 2 with a word held
    do_reset();
    cmd_ready = 1'b0;
    send_cmd(32'h1234_5678);
    tick(5);
    check_eq("t6_pre_cv", {63'd0, cmd_valid}, 64'd1);
    send_byte(8'h0D, 1'b1);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, CPB);
    drive_bit(1'b0, CPB / 2);
    reset_n = 1'b0;
    #1;
    check_eq("t6_rst_cv", {63'd0, cmd_valid}, 64'd0);
    check_eq("t6_rst_cmd", {32'd0, cmd_data}, 64'd0);
    check_eq("t6_rst_bdata", {56'd0, byte_data}, 64'd0);
    check_eq("t6_rst_count", {61'd0, byte_count}, 64'd0);
    check_eq("t6_rst_pulses", {60'd0, byte_valid, frame_err, timeout_err, overrun}, 64'd0);
    uart_rx = 1'b1;
    tick(3);
    reset_n = 1'b1;
    cmd_ready = 1'b1;
    tick(3);
    nc = cmd_log.size();
    send_cmd(32'hCAFE_F00D);
    tick(20);
    check_eq("t6_ncmd", 64'(cmd_log.size() - nc), 64'd1);
    check_eq("t6_cmd", {32'd0, cmd_log[nc]}, 64'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
